// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, latencies, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Codes 7-10 are only decoded when MDU_MADD_EN is defined.
package mdu_pkg;

    localparam logic [3:0] MD_OP_NOP   = 4'd0;
    localparam logic [3:0] MD_OP_MULT  = 4'd1;
    localparam logic [3:0] MD_OP_MULTU = 4'd2;
    localparam logic [3:0] MD_OP_DIV   = 4'd3;
    localparam logic [3:0] MD_OP_DIVU  = 4'd4;
    localparam logic [3:0] MD_OP_MTHI  = 4'd5;
    localparam logic [3:0] MD_OP_MTLO  = 4'd6;
    localparam logic [3:0] MD_OP_MADD  = 4'd7;
    localparam logic [3:0] MD_OP_MADDU = 4'd8;
    localparam logic [3:0] MD_OP_MSUB  = 4'd9;
    localparam logic [3:0] MD_OP_MSUBU = 4'd10;

    localparam int MDU_MUL_LAT = 5;
    localparam int MDU_DIV_LAT = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // Busy-counter preload: the counter reaches zero in the last busy cycle.
    function automatic logic [3:0] lat_to_cnt(input int lat);
        return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// MDU control: HI/LO registers, fixed-latency MULT/DIV sequencing, MTHI/MTLO moves (MDU_MADD_EN adds MADD/MSUB family).
// Latency: MULT/MULTU(/MADD*) busy 5 cycles, DIV/DIVU busy 10 cycles, commit at the edge ending the last busy cycle; MTHI/MTLO next edge.
// Backpressure: none accepted; md_busy is registered and the hazard unit must hold issue while it is high (issues in BUSY are dropped).
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        md_start,
    input  logic        md_flush,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        md_rd_lo,
    output logic        md_busy,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;

    logic        issue_vld;
    logic        long_op;
    logic [3:0]  lat_cnt;
    logic        commit;

    logic        mul_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] b_safe, quo, rem;

    // Issue is only honoured in IDLE and never in a flushed cycle.
    assign issue_vld = md_start & ~md_flush & (state_q == MDU_IDLE);
    assign md_busy   = (state_q == MDU_BUSY);
    assign md_rdata  = md_rd_lo ? lo : hi;

    // Classify the issuing op: multi-cycle or not, and its counter preload.
    always_comb begin
        long_op = 1'b0;
        lat_cnt = 4'd0;
        case (md_op)
            MD_OP_MULT, MD_OP_MULTU: begin
                long_op = 1'b1;
                lat_cnt = lat_to_cnt(MDU_MUL_LAT);
            end
            MD_OP_DIV, MD_OP_DIVU: begin
                long_op = 1'b1;
                lat_cnt = lat_to_cnt(MDU_DIV_LAT);
            end
`ifdef MDU_MADD_EN
            MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU: begin
                long_op = 1'b1;
                lat_cnt = lat_to_cnt(MDU_MUL_LAT);
            end
`endif
            default: ;
        endcase
    end

    // Next-state logic: count down in BUSY, commit when the counter hits zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (issue_vld && long_op) begin
                    state_d = MDU_BUSY;
                    cnt_d   = lat_cnt;
                end
            end
            MDU_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = MDU_IDLE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand/op capture at issue so later changes on md_a/md_b are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q <= MD_OP_NOP;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (issue_vld && long_op) begin
            op_q <= md_op;
            a_q  <= md_a;
            b_q  <= md_b;
        end
    end

    // Arithmetic on the captured operands; only consumed at the commit edge.
    always_comb begin
        mul_signed = (op_q == MD_OP_MULT);
`ifdef MDU_MADD_EN
        mul_signed = mul_signed | (op_q == MD_OP_MADD) | (op_q == MD_OP_MSUB);
`endif
        a_ext = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = a_ext * b_ext;

        // Divide-by-zero never commits; substitute 1 so the divider stays defined.
        b_safe = (b_q == 32'd0) ? 32'd1 : b_q;
        if (op_q == MD_OP_DIV) begin
            if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                quo = 32'h8000_0000;
                rem = 32'd0;
            end else begin
                quo = $signed(a_q) / $signed(b_safe);
                rem = $signed(a_q) % $signed(b_safe);
            end
        end else begin
            quo = a_q / b_safe;
            rem = a_q % b_safe;
        end
    end

    // HI/LO update: long-op commit from BUSY, or MTHI/MTLO from IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            case (op_q)
                MD_OP_MULT, MD_OP_MULTU: {hi, lo} <= prod;
                MD_OP_DIV, MD_OP_DIVU: begin
                    if (b_q != 32'd0) begin
                        lo <= quo;
                        hi <= rem;
                    end
                end
`ifdef MDU_MADD_EN
                MD_OP_MADD, MD_OP_MADDU: {hi, lo} <= {hi, lo} + prod;
                MD_OP_MSUB, MD_OP_MSUBU: {hi, lo} <= {hi, lo} - prod;
`endif
                default: ;
            endcase
        end else if (issue_vld) begin
            case (md_op)
                MD_OP_MTHI: hi <= md_a;
                MD_OP_MTLO: lo <= md_a;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed cases with literal expectations plus randomized traffic.
// Latency: n/a. A behavioural HI/LO model is compared against the DUT every cycle.
// Backpressure: n/a. Define MDU_MADD_EN to also exercise the accumulate ops.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic        md_start;
    logic        md_flush;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_rd_lo;
    logic        md_busy;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .md_start (md_start),
        .md_flush (md_flush),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_rd_lo (md_rd_lo),
        .md_busy  (md_busy),
        .md_rdata (md_rdata),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;

    task automatic m_commit();
        longint          sa, sb, q, r, ma, mb;
        longint unsigned ua, ub;
        logic [63:0]     p, acc;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        ua = longint'(m_a);
        ub = longint'(m_b);
        acc = {m_hi, m_lo};
        case (m_op)
            MD_OP_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; end
            MD_OP_MULTU: begin p = ua * ub; {m_hi, m_lo} = p; end
            MD_OP_DIV: if (m_b != 0) begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q  = ma / mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                r  = sa - q * sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            MD_OP_DIVU: if (m_b != 0) begin
                m_lo = 32'(ua / ub);
                m_hi = 32'(ua % ub);
            end
`ifdef MDU_MADD_EN
            MD_OP_MADD:  begin p = sa * sb; {m_hi, m_lo} = acc + p; end
            MD_OP_MADDU: begin p = ua * ub; {m_hi, m_lo} = acc + p; end
            MD_OP_MSUB:  begin p = sa * sb; {m_hi, m_lo} = acc - p; end
            MD_OP_MSUBU: begin p = ua * ub; {m_hi, m_lo} = acc - p; end
`endif
            default: ;
        endcase
    endtask

    function automatic int m_latency(input logic [3:0] op);
        case (op)
            MD_OP_MULT, MD_OP_MULTU: return 5;
            MD_OP_DIV, MD_OP_DIVU:   return 10;
`ifdef MDU_MADD_EN
            MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU: return 5;
`endif
            default: return 0;
        endcase
    endfunction

    // Model advances on each rising edge from the inputs the DUT also sees.
    always @(posedge clk) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_commit();
        end else if (md_start && !md_flush) begin
            if (m_latency(md_op) > 0) begin
                m_left = m_latency(md_op);
                m_op = md_op; m_a = md_a; m_b = md_b;
            end else if (md_op == MD_OP_MTHI) begin
                m_hi = md_a;
            end else if (md_op == MD_OP_MTLO) begin
                m_lo = md_a;
            end
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, md_busy}, {31'd0, m_left > 0});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("rdata", md_rdata, md_rd_lo ? m_lo : m_hi);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        md_op = op; md_a = a; md_b = b; md_flush = fl; md_start = 1'b1;
        cyc(1);
        md_start = 1'b0; md_flush = 1'b0; md_op = MD_OP_NOP;
        md_a = $urandom; md_b = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (md_busy === 1'b1 && n < 40) begin
            n++;
            cyc(1);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b0; md_op = MD_OP_NOP; md_start = 1'b0; md_flush = 1'b0;
        md_a = 0; md_b = 0; md_rd_lo = 1'b0;
        cyc(2);
        reset = 1'b1;
        chk_en = 1'b1;
        chk("reset_busy", {31'd0, md_busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        // Signed multiply: -2 * 3 = -6.
        issue(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle(n);
        chk("mult_busy_len", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // Signed divide: -7 / 2 = -3 rem -1.
        issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(n);
        chk("div_busy_len", n, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // Divide by zero: full busy time, no write.
        issue(MD_OP_DIVU, 32'd7, 32'd0, 1'b0);
        wait_idle(n);
        chk("divz_busy_len", n, 32'd10);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        // Flushed MTHI is dropped; unflushed one lands next edge without busy.
        issue(MD_OP_MTHI, 32'h0000_1234, 32'd0, 1'b1);
        chk("mthi_flush_hi", hi, 32'hFFFF_FFFF);
        chk("mthi_flush_busy", {31'd0, md_busy}, 32'd0);
        issue(MD_OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_busy", {31'd0, md_busy}, 32'd0);

        // MTLO issued in busy cycle 2 must be ignored.
        issue(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        md_rd_lo = 1'b1;
        cyc(1);
        md_op = MD_OP_MTLO; md_a = 32'hDEAD_BEEF; md_start = 1'b1;
        cyc(1);
        md_start = 1'b0; md_op = MD_OP_NOP;
        chk("multu_rdata_old", md_rdata, 32'hFFFF_FFFD);
        wait_idle(n);
        chk("multu_busy_len", n + 2, 32'd5);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        chk("multu_rdata", md_rdata, 32'h0000_0001);

        // Reset in busy cycle 4 discards the divide.
        issue(MD_OP_DIV, 32'd100, 32'd7, 1'b0);
        cyc(3);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        cyc(15);
        chk("rst_nocommit_hi", hi, 32'd0);
        chk("rst_nocommit_lo", lo, 32'd0);

`ifdef MDU_MADD_EN
        issue(MD_OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(MD_OP_MTHI, 32'd0, 32'd0, 1'b0);
        issue(MD_OP_MADDU, 32'd1, 32'd1, 1'b0);
        wait_idle(n);
        chk("maddu_busy_len", n, 32'd5);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
`endif

        // Randomized traffic, including issues during busy, flushes and rare resets.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom % 250) != 0;
            md_start = ($urandom % 3) == 0;
            md_flush = ($urandom % 8) == 0;
            md_op    = 4'($urandom % 12);
            md_a     = pick();
            md_b     = pick();
            md_rd_lo = $urandom % 2;
            cyc(1);
        end
        reset = 1'b1; md_start = 1'b0; md_flush = 1'b0;
        cyc(15);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port md_op, input, 4 bits: operation code from mdu_pkg; the E stage issues it.
REQ-004 SHALL have port md_start, input, 1 bit: issue strobe, qualifying md_op for one cycle.
REQ-005 SHALL have port md_flush, input, 1 bit: exception/interrupt cancel; suppresses any same-cycle issue.
REQ-006 SHALL have ports md_a and md_b, input, 32 bits each: rs and rt operands.
REQ-007 SHALL have port md_rd_lo, input, 1 bit: read select, 0 = HI, 1 = LO.
REQ-008 SHALL have port md_busy, output, 1 bit: a mult/div is in progress.
REQ-009 SHALL have port md_rdata, output, 32 bits: combinational HI or LO, per md_rd_lo.
REQ-010 SHALL have ports hi and lo, output, 32 bits each: architectural registers.

Function
REQ-011 SHALL decode these md_op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; all other codes SHALL be NOP.
REQ-012 SHALL implement the FSM states IDLE and BUSY; the transition IDLE->BUSY occurs on a valid issue (md_start=1, md_flush=0) of MULT, MULTU, DIV or DIVU.
REQ-013 SHALL latch md_a, md_b and md_op at issue; operand changes during BUSY SHALL have no effect.
REQ-014 SHALL fix latency L: MULT/MULTU L=5, DIV/DIVU L=10. An issue at edge T SHALL hold md_busy=1 for cycles T+1..T+L. HI/LO SHALL update at the edge ending cycle T+L, and md_busy SHALL fall at that same edge.
REQ-015 SHALL drive md_busy from the registered state only, never combinationally from md_start.
REQ-016 SHALL compute MULT as a signed 32x32->64 product and MULTU as an unsigned one: HI = [63:32], LO = [31:0].
REQ-017 SHALL compute DIV/DIVU as LO = quotient and HI = remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-018 SHALL, on divide by zero, leave HI/LO unchanged while still running the full 10 busy cycles.
REQ-019 SHALL, for a valid MTHI/MTLO issue in IDLE, write md_a to HI/LO at the next edge, with no busy.
REQ-020 SHALL ignore any issue (start, MTHI, MTLO) while BUSY; the hazard unit guarantees none occurs.
REQ-021 SHALL let md_flush cancel only same-cycle issues; an operation already in BUSY SHALL run to completion and commit.
REQ-022 SHALL have md_rdata reflect committed HI/LO only; during BUSY it returns the pre-operation values.
REQ-023 SHALL use a 4-bit down-counter, loaded with L-1 at issue; BUSY exits when the counter reaches 0.

Reset
REQ-024 SHALL, with reset=0 at an edge, set the state to IDLE and clear counter=0, hi=0, lo=0, md_busy=0.
REQ-025 SHALL discard an in-flight operation on reset mid-operation, with no commit.
REQ-026 SHALL give reset priority over any same-cycle issue.

Configuration
REQ-027 SHALL support the macro MDU_MADD_EN; when defined, add ops 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, each with L=5. The result SHALL be {HI,LO} plus or minus the signed/unsigned product, committed with 64-bit wraparound.
REQ-028 SHALL, when MDU_MADD_EN is undefined, treat codes 7-10 as NOP and omit the accumulate logic.

Structure
REQ-029 SHALL place the md_op code localparams, MDU_MUL_LAT=5, MDU_DIV_LAT=10 and the state encoding in shared package mdu_pkg.
REQ-030 SHALL be a single module with no sub-module; the product and quotient SHALL come from behavioural operators, registered at the commit edge.

Verification
REQ-031 SHALL cover: MULT issue with a=0xFFFFFFFE, b=3 -> busy for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 SHALL cover: DIV with a=-7, b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with a=7, b=0 -> busy for 10 cycles, hi/lo unchanged.
REQ-033 SHALL cover: MTHI a=0x1234 with md_flush=1 -> hi unchanged; repeated with md_flush=0 -> hi=0x1234 next cycle, busy never asserted.
REQ-034 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF, then MTLO issued in busy cycle 2 -> MTLO ignored; final hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 SHALL cover: DIV issued, then reset=0 in busy cycle 4 -> next cycle busy=0, hi=lo=0, and no later commit.
REQ-036 SHALL cover, with MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then MADDU 1x1 -> hi=1, lo=0.
